// File: rtl/xgmii_rx_checker.sv
// ---------------------------------------------------------------------------
// xgmii_rx_checker
//   Receive-side checker for a 64-bit data / 8-bit control XGMII-style stream.
//   Classifies each column as IDLE / START / DATA / TERMINATE, measures the
//   byte length of every frame, reports protocol violations and keeps
//   saturating good-frame and error-event counters.
//
//   Optional feature macro: RX_CHECK_PATTERN_EN
//     defined   -> every payload byte must equal DATA_PATTERN; a mismatch is
//                  remembered and reported as error code 4 when the frame
//                  terminates.
//     undefined -> payload byte values are not inspected.
//
// Ports
//   clk            rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_rx_data      received data column, lane 0 = bits [7:0]
//   i_rx_ctrl      received control flags, one per lane
//   o_frame_done   one-cycle pulse when a frame closes (good or bad)
//   o_frame_len    byte count of the closed frame, valid with o_frame_done
//   o_frame_err    error flag, qualified by o_frame_done or o_idle_err
//   o_err_code     0 none, 1 bad ctrl, 2 bad idle, 3 bad TERM tail,
//                  4 pattern, 5 length overflow, 6 START inside payload
//   o_idle_err     one-cycle pulse for an error outside a frame
//   o_frame_count  good frames received, saturating
//   o_err_count    error events, saturating
// ---------------------------------------------------------------------------
module xgmii_rx_checker #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = 8,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  TERM_CODE       = 8'hFD,
  parameter logic [7:0]  DATA_PATTERN    = 8'hAA,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_FRAME_BYTES = 2048
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_done,
  output logic [LEN_WIDTH-1:0]  o_frame_len,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code,
  output logic                  o_idle_err,
  output logic [31:0]           o_frame_count,
  output logic [31:0]           o_err_count
);

  localparam int unsigned LANES   = CTRL_WIDTH;
  localparam int unsigned K_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W   = LEN_WIDTH + 1;
  localparam int unsigned CTR_W   = 32;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CTRL    = 3'd1;
  localparam logic [2:0] ERR_IDLE    = 3'd2;
  localparam logic [2:0] ERR_TERM    = 3'd3;
  localparam logic [2:0] ERR_PATTERN = 3'd4;
  localparam logic [2:0] ERR_LENGTH  = 3'd5;
  localparam logic [2:0] ERR_START   = 3'd6;

  // START column carries 7 payload bytes in lanes 1..7.
  localparam logic [LEN_WIDTH-1:0] START_LEN = LEN_WIDTH'(LANES - 1);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0]     COL_BYTES = CNT_W'(LANES);

`ifdef RX_CHECK_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_RESYNC  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 pat_err_q, pat_err_d;
  logic                 done_q, done_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ferr_q, ferr_d;
  logic [2:0]           code_q, code_d;
  logic                 ierr_q, ierr_d;
  logic [CTR_W-1:0]     frame_count_q, frame_count_d;
  logic [CTR_W-1:0]     err_count_q, err_count_d;

  // Per-lane byte classification
  logic [LANES-1:0] lane_idle;
  logic [LANES-1:0] lane_term;
  logic [LANES-1:0] lane_bad;

  always_comb begin
    lane_idle = '0;
    lane_term = '0;
    lane_bad  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_idle[i] = (i_rx_data[i*8 +: 8] == IDLE_CODE);
      lane_term[i] = (i_rx_data[i*8 +: 8] == TERM_CODE);
      lane_bad[i]  = (i_rx_data[i*8 +: 8] != DATA_PATTERN);
    end
  end

  // Column classification
  logic             is_idle_col;
  logic             is_start_col;
  logic             is_data_col;
  logic             has_ctrl;
  logic [K_W-1:0]   term_k;
  logic [LANES-1:0] below_mask;
  logic [LANES-1:0] above_mask;
  logic             term_lead;
  logic             term_shape_ok;
  logic             start_pat_bad;
  logic             data_pat_bad;
  logic             term_pat_bad;

  always_comb begin
    is_idle_col  = (&i_rx_ctrl) && (&lane_idle);
    is_start_col = (i_rx_ctrl == LANES'(1)) && (i_rx_data[7:0] == START_CODE);
    is_data_col  = (i_rx_ctrl == '0);
    has_ctrl     = |i_rx_ctrl;

    // Lowest lane carrying a control character is the TERM candidate.
    term_k = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (i_rx_ctrl[i]) begin
        term_k = K_W'(i);
      end
    end

    below_mask = (LANES'(1) << term_k) - LANES'(1);
    above_mask = ~(below_mask | (LANES'(1) << term_k));

    // Lead lane holds TERM; lanes above must be control IDLE characters.
    term_lead     = has_ctrl && lane_term[term_k];
    term_shape_ok = ((i_rx_ctrl & above_mask) == above_mask) &&
                    ((lane_idle & above_mask) == above_mask);

    start_pat_bad = PAT_EN && (|(lane_bad & ~LANES'(1)));
    data_pat_bad  = PAT_EN && (|lane_bad);
    term_pat_bad  = PAT_EN && (|(lane_bad & below_mask));
  end

  // Candidate lengths, one bit wider so overflow is visible
  logic [CNT_W-1:0] data_sum;
  logic [CNT_W-1:0] term_sum;

  always_comb begin
    data_sum = CNT_W'(count_q) + COL_BYTES;
    term_sum = CNT_W'(count_q) + CNT_W'(term_k);
  end

  // Next-state and registered-output decode
  logic good_inc;
  logic err_inc;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pat_err_d = pat_err_q;
    done_d    = 1'b0;
    len_d     = '0;
    ferr_d    = 1'b0;
    code_d    = ERR_NONE;
    ierr_d    = 1'b0;
    good_inc  = 1'b0;
    err_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_idle_col) begin
          state_d = ST_IDLE;
        end else if (is_start_col) begin
          state_d   = ST_PAYLOAD;
          count_d   = START_LEN;
          pat_err_d = start_pat_bad;
        end else begin
          ierr_d  = 1'b1;
          ferr_d  = 1'b1;
          code_d  = ERR_IDLE;
          err_inc = 1'b1;
        end
      end

      ST_PAYLOAD: begin
        if (is_start_col) begin
          // Close the running frame and immediately measure the new one.
          done_d    = 1'b1;
          len_d     = count_q;
          ferr_d    = 1'b1;
          code_d    = ERR_START;
          err_inc   = 1'b1;
          count_d   = START_LEN;
          pat_err_d = start_pat_bad;
        end else if (is_data_col) begin
          if (data_sum > MAX_CNT) begin
            done_d  = 1'b1;
            len_d   = MAX_LEN;
            ferr_d  = 1'b1;
            code_d  = ERR_LENGTH;
            err_inc = 1'b1;
            state_d = ST_RESYNC;
          end else begin
            count_d   = LEN_WIDTH'(data_sum);
            pat_err_d = pat_err_q | data_pat_bad;
          end
        end else if (term_lead) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!term_shape_ok) begin
            len_d   = LEN_WIDTH'(term_sum);
            ferr_d  = 1'b1;
            code_d  = ERR_TERM;
            err_inc = 1'b1;
          end else if (term_sum > MAX_CNT) begin
            len_d   = MAX_LEN;
            ferr_d  = 1'b1;
            code_d  = ERR_LENGTH;
            err_inc = 1'b1;
            state_d = ST_RESYNC;
          end else if (pat_err_q || term_pat_bad) begin
            len_d   = LEN_WIDTH'(term_sum);
            ferr_d  = 1'b1;
            code_d  = ERR_PATTERN;
            err_inc = 1'b1;
          end else begin
            len_d    = LEN_WIDTH'(term_sum);
            good_inc = 1'b1;
          end
        end else begin
          // Control character that is neither START nor a TERM lead.
          done_d  = 1'b1;
          len_d   = count_q;
          ferr_d  = 1'b1;
          code_d  = ERR_CTRL;
          err_inc = 1'b1;
          state_d = ST_RESYNC;
        end
      end

      ST_RESYNC: begin
        // Silent until the link shows IDLE or a fresh START.
        if (is_idle_col) begin
          state_d = ST_IDLE;
        end else if (is_start_col) begin
          state_d   = ST_PAYLOAD;
          count_d   = START_LEN;
          pat_err_d = start_pat_bad;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_count_d = frame_count_q;
    if (good_inc && (frame_count_q != '1)) begin
      frame_count_d = frame_count_q + CTR_W'(1);
    end

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != '1)) begin
      err_count_d = err_count_q + CTR_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      pat_err_q     <= 1'b0;
      done_q        <= 1'b0;
      len_q         <= '0;
      ferr_q        <= 1'b0;
      code_q        <= ERR_NONE;
      ierr_q        <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pat_err_q     <= pat_err_d;
      done_q        <= done_d;
      len_q         <= len_d;
      ferr_q        <= ferr_d;
      code_q        <= code_d;
      ierr_q        <= ierr_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign o_frame_done  = done_q;
  assign o_frame_len   = len_q;
  assign o_frame_err   = ferr_q;
  assign o_err_code    = code_q;
  assign o_idle_err    = ierr_q;
  assign o_frame_count = frame_count_q;
  assign o_err_count   = err_count_q;

endmodule
